// File: rtl/therm_dac_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : therm_dac_encoder_if
// Description : Handshake bundle for the binary-to-thermometer DAC encoder.
//               The master side supplies codes and drains unary words; the
//               slave side is the encoder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface therm_dac_encoder_if #(
    parameter int N_BITS = 4,
    parameter int N_ELEM = 15
);
    // Input side: binary code offered to the encoder
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] in_code;

    // Mode and pointer control, sampled by the encoder
    logic              dwa_en;
    logic              ptr_clr;

    // Output side: registered unary element enables
    logic              out_valid;
    logic              out_ready;
    logic [N_ELEM-1:0] therm_out;
    logic [N_BITS-1:0] ptr;

    // Code producer / word consumer
    modport master (
        output in_valid,
        output in_code,
        output dwa_en,
        output ptr_clr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  therm_out,
        input  ptr
    );

    // Encoder
    modport slave (
        input  in_valid,
        input  in_code,
        input  dwa_en,
        input  ptr_clr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output therm_out,
        output ptr
    );
endinterface
`default_nettype wire

// File: rtl/therm_dac_encoder.sv
`default_nettype none
// ============================================================================
// Module      : therm_dac_encoder
// Description : Binary-to-thermometer encoder for the unary feedback DAC.
//               A k-valued code enables k of the N_ELEM elements. With data
//               weighted averaging enabled, the enabled run starts at a
//               wrap-around pointer that advances by k on every word, so
//               each element is used equally often over time.
//               Single registered output stage, full throughput, 1-cycle
//               latency, no combinational path from code to output.
// Revision    : 1.0 - initial release
// ============================================================================
module therm_dac_encoder #(
    parameter int N_BITS = 4,
    parameter int N_ELEM = 15
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    therm_dac_encoder_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Element count at the widened pointer-arithmetic width
    localparam logic [N_BITS:0] c_ELEM      = (N_BITS+1)'(N_ELEM);

    // Output register state: EMPTY holds nothing, FULL presents a word
    localparam logic [0:0]      c_ST_EMPTY  = 1'b0;
    localparam logic [0:0]      c_ST_FULL   = 1'b1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [N_ELEM-1:0] r_therm;
    logic [N_BITS-1:0] r_ptr;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;

    assign w_out_valid = (r_state == c_ST_FULL);
    // A word can be taken whenever the output slot is free or is draining now
    assign w_in_ready  = !w_out_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.therm_out = r_therm;
    assign bus.ptr       = r_ptr;

    // ------------------------------------------------------------------------
    // Effective pointer: a clear request takes effect on the word it rides with
    // ------------------------------------------------------------------------
    logic [N_BITS-1:0] w_eff;

    assign w_eff = bus.ptr_clr ? '0 : r_ptr;

    // ------------------------------------------------------------------------
    // Plain thermometer mask: element i is on when i < k
    // ------------------------------------------------------------------------
    logic [N_ELEM-1:0] w_therm;

    for (genvar i = 0; i < N_ELEM; i++) begin : g_therm
        assign w_therm[i] = ((N_BITS+1)'(i) < {1'b0, bus.in_code});
    end

    // ------------------------------------------------------------------------
    // Rotation by the effective pointer within N_ELEM positions.
    // Output element j takes mask bit (j - eff) mod N_ELEM; N_ELEM is added
    // first so the difference stays non-negative, then removed at most once.
    // ------------------------------------------------------------------------
    logic [N_ELEM-1:0] w_rot;

    for (genvar j = 0; j < N_ELEM; j++) begin : g_rot
        logic [N_BITS:0]   w_src_raw;
        logic [N_BITS:0]   w_src_wrap;
        logic [N_BITS-1:0] w_src;

        assign w_src_raw  = (N_BITS+1)'(j) + c_ELEM - {1'b0, w_eff};
        assign w_src_wrap = (w_src_raw >= c_ELEM) ? (w_src_raw - c_ELEM)
                                                  : w_src_raw;
        assign w_src      = N_BITS'(w_src_wrap);
        assign w_rot[j]   = w_therm[w_src];
    end

    // ------------------------------------------------------------------------
    // Next pointer for averaging mode: (eff + k) mod N_ELEM with a single
    // conditional subtract; eff < N_ELEM and k <= N_ELEM keep the sum below
    // 2*N_ELEM, so one subtract always suffices.
    // ------------------------------------------------------------------------
    logic [N_BITS:0]   w_sum;
    logic [N_BITS-1:0] w_ptr_dwa;

    assign w_sum     = {1'b0, w_eff} + {1'b0, bus.in_code};
    assign w_ptr_dwa = (w_sum >= c_ELEM) ? N_BITS'(w_sum - c_ELEM)
                                         : N_BITS'(w_sum);

    // ------------------------------------------------------------------------
    // Word and pointer to load on accept, selected by the sampled mode
    // ------------------------------------------------------------------------
    logic [N_ELEM-1:0] w_word;
    logic [N_BITS-1:0] w_ptr_next;

    assign w_word     = bus.dwa_en ? w_rot     : w_therm;
    assign w_ptr_next = bus.dwa_en ? w_ptr_dwa : w_eff;

    // Output register state machine: load on accept, drain on transfer,
    // hold everything while stalled; a standalone clear only zeroes the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_EMPTY;
            r_therm <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= c_ST_FULL;
                        r_therm <= w_word;
                        r_ptr   <= w_ptr_next;
                    end else if (bus.ptr_clr) begin
                        r_ptr   <= '0;
                    end
                end
                c_ST_FULL: begin
                    if (w_accept) begin
                        // Old word leaves and the new one lands in the same edge
                        r_therm <= w_word;
                        r_ptr   <= w_ptr_next;
                    end else begin
                        if (bus.out_ready) begin
                            r_state <= c_ST_EMPTY;
                        end
                        if (bus.ptr_clr) begin
                            r_ptr   <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_therm_dac_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_therm_dac_encoder
// Description : Self-checking bench for therm_dac_encoder. Directed cases
//               from the encoding rules followed by randomized codes, modes,
//               pointer clears and stalls, all compared against a reference
//               model computed with plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_therm_dac_encoder;

    localparam int N_BITS = 4;
    localparam int N_ELEM = 15;

    logic clk;
    logic rst_n;

    therm_dac_encoder_if #(.N_BITS(N_BITS), .N_ELEM(N_ELEM)) bus ();

    therm_dac_encoder #(.N_BITS(N_BITS), .N_ELEM(N_ELEM)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_ptr   = 0;
    logic [14:0] m_word  = '0;
    bit          m_valid = 1'b0;
    int          m_k     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // k enabled elements starting at element e, wrapping past the top
    function automatic logic [14:0] ref_word(input int k, input int e, input bit dwa);
        logic [14:0] w;
        w = '0;
        for (int n = 0; n < k; n++) begin
            if (dwa) w[(e + n) % N_ELEM] = 1'b1;
            else     w[n] = 1'b1;
        end
        return w;
    endfunction

    // One clock: drive at the falling edge, check in_ready, update the model,
    // cross the rising edge and check the registered outputs at the next fall
    task automatic cyc(input bit v, input int k, input bit dwa, input bit clr, input bit ordy);
        bit acc;
        int e;
        bus.in_valid  = v;
        bus.in_code   = 4'(k);
        bus.dwa_en    = dwa;
        bus.ptr_clr   = clr;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || ordy));
        acc = v && (!m_valid || ordy);
        e   = clr ? 0 : m_ptr;
        if (acc) begin
            m_word  = ref_word(k, e, dwa);
            m_ptr   = dwa ? (e + k) % N_ELEM : e;
            m_valid = 1'b1;
            m_k     = k;
        end else begin
            if (m_valid && ordy) m_valid = 1'b0;
            if (clr) m_ptr = 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("ptr", 32'(bus.ptr), 32'(m_ptr));
        if (m_valid) begin
            chk("therm_out", 32'(bus.therm_out), 32'(m_word));
            chk("popcount", 32'($countones(bus.therm_out)), 32'(m_k));
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.dwa_en    = 1'b0;
        bus.ptr_clr   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_therm", 32'(bus.therm_out), 32'h0000);
        chk("rst_ptr", 32'(bus.ptr), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // Plain thermometer
        cyc(1, 5, 0, 0, 1);
        chk("plain_k5", 32'(bus.therm_out), 32'h001F);
        chk("plain_k5_ptr", 32'(bus.ptr), 32'd0);
        cyc(1, 15, 0, 0, 1);
        chk("plain_k15", 32'(bus.therm_out), 32'h7FFF);

        // Averaging sequence from pointer 0
        cyc(1, 5, 1, 0, 1);
        chk("dwa_k5", 32'(bus.therm_out), 32'h001F);
        chk("dwa_k5_ptr", 32'(bus.ptr), 32'd5);
        cyc(1, 7, 1, 0, 1);
        chk("dwa_k7", 32'(bus.therm_out), 32'h0FE0);
        chk("dwa_k7_ptr", 32'(bus.ptr), 32'd12);
        cyc(1, 6, 1, 0, 1);
        chk("dwa_k6_wrap", 32'(bus.therm_out), 32'h7007);
        chk("dwa_k6_ptr", 32'(bus.ptr), 32'd3);

        // Boundaries at pointer 3
        cyc(1, 15, 1, 0, 1);
        chk("dwa_k15", 32'(bus.therm_out), 32'h7FFF);
        chk("dwa_k15_ptr", 32'(bus.ptr), 32'd3);
        cyc(1, 0, 1, 0, 1);
        chk("dwa_k0", 32'(bus.therm_out), 32'h0000);
        chk("dwa_k0_valid", 32'(bus.out_valid), 32'd1);
        chk("dwa_k0_ptr", 32'(bus.ptr), 32'd3);

        // Backpressure: word held, k=9 waits, mode toggling has no effect
        for (int n = 0; n < 4; n++) begin
            cyc(1, 9, n[0], 0, 0);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_therm", 32'(bus.therm_out), 32'h0000);
        end
        cyc(1, 9, 1, 0, 1);
        chk("release_k9", 32'(bus.therm_out), 32'h0FF8);
        chk("release_k9_ptr", 32'(bus.ptr), 32'd12);

        // Pointer clear riding on an accept
        cyc(1, 4, 1, 1, 1);
        chk("clr_k4", 32'(bus.therm_out), 32'h000F);
        chk("clr_k4_ptr", 32'(bus.ptr), 32'd4);

        // Standalone clear with the output drained
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 1, 1);
        chk("clr_idle_ptr", 32'(bus.ptr), 32'd0);

        // Randomized codes, modes, clears and stalls
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 4) != 0, int'($urandom % 16), 1'($urandom % 2),
                ($urandom % 8) == 0, ($urandom % 3) != 0);
        end

        // Asynchronous reset while a word is held
        cyc(1, 11, 1, 0, 0);
        cyc(1, 3, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_therm", 32'(bus.therm_out), 32'h0000);
        chk("arst_ptr", 32'(bus.ptr), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        m_ptr   = 0;
        m_valid = 1'b0;
        m_word  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 2, 1, 0, 1);
        chk("post_rst_k2", 32'(bus.therm_out), 32'h0003);
        chk("post_rst_ptr", 32'(bus.ptr), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
